app_loopback_buf: RTL and testbench
===================================

// Module: app_loopback_buf
// PURPOSE
//  Parametrised buffered loopback application. Sits between the usb_cdc OUT stream (host->device) and IN stream
//  (device->host) on the application clock. Bytes pass through a DEPTH-entry FIFO and a per-byte transform
//  selected by mode_i. Also drives a stretched activity indicator for the board LED.
// PARAMETERS
//  DEPTH       16         FIFO entries; power of 2, >=2
//  ACT_CYCLES  4800000    activity hold time in clk_i cycles (25 ms at 192 MHz); >=1
// PORTS
//  clk_i       in   1              application clock
//  rstn_i      in   1              synchronous reset, active low
//  rx_data_i   in   8              byte from usb_cdc out_data_o
//  rx_valid_i  in   1              from usb_cdc out_valid_o
//  rx_ready_o  out  1              to usb_cdc out_ready_i
//  tx_data_o   out  8              byte to usb_cdc in_data_i
//  tx_valid_o  out  1              to usb_cdc in_valid_i
//  tx_ready_i  in   1              from usb_cdc in_ready_o
//  mode_i      in   2              transform select (see BEHAVIOUR)
//  flush_i     in   1              synchronous FIFO clear
//  level_o     out  $clog2(DEPTH)+1  current FIFO occupancy
//  act_o       out  1              activity indicator
//  rx_count_o  out  32             bytes accepted (stats)
//  tx_count_o  out  32             bytes delivered (stats)
// BEHAVIOUR
//  - Single clock clk_i; reset synchronous, active-low on rstn_i. All state changes on rising clk_i only.
//  - Reset: FIFO empty, level_o=0, tx_valid_o=0, rx_ready_o=1, act_o=0, rx_count_o=tx_count_o=0.
//    tx_data_o is don't-care while tx_valid_o=0.
//  - Handshake: push when rx_valid_i&&rx_ready_o; pop when tx_valid_o&&tx_ready_i.
//    rx_ready_o = !full. tx_valid_o = !empty.
//    tx_data_o = FIFO head, stable while tx_valid_o && !tx_ready_i.
//  - Latency: byte pushed in cycle N is visible on tx_data_o/tx_valid_o in cycle N+1 (FIFO was empty).
//  - Transform is applied at push; mode_i is sampled in the push cycle. A mode change affects only later pushes.
//    00 ECHO   : d
//    01 INVERT : ~d
//    10 INCR   : d+1 mod 256 (8'hFF -> 8'h00)
//    11 CASE   : d^8'h20 if d in 'A'..'Z' or 'a'..'z', else d
//  - Simultaneous push+pop: level unchanged, both happen.
//    Full: rx_ready_o=0, so no push even if a pop occurs that cycle. Empty: no pop possible.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level range is 0..DEPTH.
//  - flush_i=1: next cycle FIFO empty, level_o=0. Any same-cycle push/pop is discarded. Counters are not affected.
//  - act_o: any push or pop reloads the hold counter to ACT_CYCLES-1 and sets act_o=1.
//    act_o=0 after ACT_CYCLES idle cycles. Counter saturates at 0.
//  - Reset asserted mid-transfer: all state returns to reset values on that edge. Buffered bytes are lost.
// CONFIGURATION
//  - Macro LOOPBACK_STATS_EN.
//  - Defined: rx_count_o increments on each push, tx_count_o on each pop. Both are 32-bit and wrap 2^32-1 -> 0.
//    flush_i does not clear them; only reset does.
//  - Undefined: counter registers are not built; rx_count_o and tx_count_o are tied to 32'd0. Ports remain present.
// STRUCTURE
//  - Shared package app_loopback_pkg: mode encodings MODE_ECHO/MODE_INVERT/MODE_INCR/MODE_CASE (2-bit),
//    ASCII bounds, case-toggle mask 8'h20.
//  - Sub-module sync_fifo (WIDTH, DEPTH): storage, pointers, level, full/empty, flush.
//  - Transform, activity timer and stats live in the top.
// TESTING
//  1. Reset, ECHO: push 8'h41,8'h42,8'h43 with tx_ready_i=1 -> tx_data_o 41,42,43 in order,
//     first one cycle after its push.
//  2. Modes: push 8'h61 under each mode -> 61 / 9E / 62 / 41. Push 8'hFF in INCR -> 00.
//     Push 8'h5B in CASE -> 5B.
//  3. Backpressure: tx_ready_i=0, push DEPTH bytes -> level_o=DEPTH, rx_ready_o=0.
//     The 17th byte is held by the source. Release -> all 16 bytes out in order, then the 17th.
//  4. Simultaneous: level=3, push and pop in the same cycle -> level stays 3, order preserved.
//  5. Flush: level=5, flush_i with rx_valid_i=1 -> level_o=0, tx_valid_o=0 next cycle, pushed byte discarded.
//  6. Activity/stats: ACT_CYCLES=8, one push -> act_o high 8 cycles then 0.
//     With LOOPBACK_STATS_EN: 3 pushes, 2 pops -> rx_count_o=3, tx_count_o=2; without the macro -> both 0.
//     Reset mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/app_loopback_pkg.sv
// Shared definitions for the buffered loopback application: transform mode
// encodings, ASCII letter bounds and the byte transform applied at push time.
package app_loopback_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO   = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_INCR   = 2'b10,
    MODE_CASE   = 2'b11
  } mode_e;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam logic [7:0] CASE_MASK     = 8'h20;

  // Per-byte transform; the case toggle only touches ASCII letters so
  // punctuation such as '[' passes through unchanged.
  function automatic logic [7:0] applyTransform(input logic [1:0] mode,
                                                input logic [7:0] data);
    logic isAlpha;
    logic [7:0] result;
    isAlpha = ((data >= ASCII_UPPER_A) && (data <= ASCII_UPPER_Z)) ||
              ((data >= ASCII_LOWER_A) && (data <= ASCII_LOWER_Z));
    case (mode)
      MODE_ECHO:   result = data;
      MODE_INVERT: result = ~data;
      MODE_INCR:   result = data + 8'd1;
      MODE_CASE:   result = isAlpha ? (data ^ CASE_MASK) : data;
      default:     result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/app_loopback_buf_sync_fifo.sv
// Single-clock FIFO used by the loopback buffer. Pointers wrap modulo DEPTH,
// occupancy is tracked explicitly so full and empty are unambiguous, and a
// flush empties the FIFO on the next edge while discarding any same-cycle
// push or pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             doPush, doPop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Next-state for pointers and occupancy; flush overrides any transfer.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (rstn_i && !flush_i && doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign level_o = level_q;

endmodule

// File: rtl/app_loopback_buf.sv
// Buffered loopback between the usb_cdc OUT and IN streams. Incoming bytes are
// transformed according to mode_i at push time, buffered in sync_fifo and
// returned to the host. Also drives a stretched activity flag for the LED.
// Optional byte statistics are built only when LOOPBACK_STATS_EN is defined;
// otherwise rx_count_o/tx_count_o read as zero.
module app_loopback_buf #(
  parameter int DEPTH      = 16,
  parameter int ACT_CYCLES = 4800000
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  input  logic [1:0]             mode_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   act_o,
  output logic [31:0]            rx_count_o,
  output logic [31:0]            tx_count_o
);

  import app_loopback_pkg::*;

  localparam int ACT_W = (ACT_CYCLES > 1) ? $clog2(ACT_CYCLES) : 1;

  logic             fifoFull, fifoEmpty;
  logic             pushEn, popEn;
  logic [7:0]       xformData;
  logic [ACT_W-1:0] actCnt_q, actCnt_d;
  logic             act_q, act_d;

  assign rx_ready_o = !fifoFull;
  assign tx_valid_o = !fifoEmpty;
  assign pushEn     = rx_valid_i && rx_ready_o;
  assign popEn      = tx_valid_o && tx_ready_i;
  assign xformData  = applyTransform(mode_i, rx_data_i);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .wdata_i (xformData),
    .rdata_o (tx_data_o),
    .level_o (level_o),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Activity hold: any handshake reloads the timer, idling counts it down to
  // zero and the flag drops on the first idle cycle after reaching zero.
  always_comb begin
    actCnt_d = actCnt_q;
    act_d    = act_q;
    if (pushEn || popEn) begin
      actCnt_d = ACT_W'(ACT_CYCLES - 1);
      act_d    = 1'b1;
    end else if (actCnt_q != '0) begin
      actCnt_d = actCnt_q - 1'b1;
    end else begin
      act_d = 1'b0;
    end
  end

  // Activity timer registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      actCnt_q <= '0;
      act_q    <= 1'b0;
    end else begin
      actCnt_q <= actCnt_d;
      act_q    <= act_d;
    end
  end

  assign act_o = act_q;

`ifdef LOOPBACK_STATS_EN
  logic [31:0] rxCount_q, rxCount_d;
  logic [31:0] txCount_q, txCount_d;

  // Handshake counters; they wrap naturally and only reset clears them.
  always_comb begin
    rxCount_d = rxCount_q;
    txCount_d = txCount_q;
    if (pushEn) rxCount_d = rxCount_q + 32'd1;
    if (popEn)  txCount_d = txCount_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rxCount_q <= '0;
      txCount_q <= '0;
    end else begin
      rxCount_q <= rxCount_d;
      txCount_q <= txCount_d;
    end
  end

  assign rx_count_o = rxCount_q;
  assign tx_count_o = txCount_q;
`else
  assign rx_count_o = 32'd0;
  assign tx_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_app_loopback_buf.sv
// Self-checking bench for app_loopback_buf with a queue-based reference model.
// Build with LOOPBACK_STATS_EN defined to exercise the statistics counters.
module tb_app_loopback_buf;

  localparam int DEPTH      = 16;
  localparam int ACT_CYCLES = 8;
  localparam int LW         = $clog2(DEPTH) + 1;
`ifdef LOOPBACK_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, rx_valid, tx_ready, flush;
  logic [7:0]    rx_data;
  logic [1:0]    mode;
  logic          rx_ready, tx_valid, act;
  logic [7:0]    tx_data;
  logic [LW-1:0] level;
  logic [31:0]   rx_count, tx_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mQ[$];
  int unsigned mRx, mTx;
  int          mHold;

  always #5 clk = ~clk;

  app_loopback_buf #(
    .DEPTH      (DEPTH),
    .ACT_CYCLES (ACT_CYCLES)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .mode_i     (mode),
    .flush_i    (flush),
    .level_o    (level),
    .act_o      (act),
    .rx_count_o (rx_count),
    .tx_count_o (tx_count)
  );

  // Reference transform written with plain arithmetic.
  function automatic logic [7:0] modelXform(input logic [1:0] m, input logic [7:0] d);
    int v;
    v = int'(d);
    case (m)
      2'd0: ;
      2'd1: v = 255 - v;
      2'd2: v = (v + 1) % 256;
      default: begin
        if (v >= 65 && v <= 90) v = v + 32;
        else if (v >= 97 && v <= 122) v = v - 32;
      end
    endcase
    return 8'(v);
  endfunction

  function automatic logic [31:0] expCount(input int unsigned v);
    return STATS_ON ? 32'(v) : 32'd0;
  endfunction

  // Advance one clock and update the reference model; outputs settle 1 ns later.
  task automatic tick();
    bit doPush, doPop;
    logic [7:0] din;
    logic [1:0] dm;
    doPush = rx_valid && (mQ.size() < DEPTH);
    doPop  = tx_ready && (mQ.size() > 0);
    din = rx_data;
    dm  = mode;
    @(posedge clk);
    if (!rstn) begin
      mQ.delete();
      mRx = 0; mTx = 0; mHold = 0;
    end else begin
      if (doPush) mRx++;
      if (doPop) mTx++;
      if (doPush || doPop) mHold = ACT_CYCLES;
      else if (mHold > 0) mHold--;
      if (flush) mQ.delete();
      else begin
        if (doPop) void'(mQ.pop_front());
        if (doPush) mQ.push_back(modelXform(dm, din));
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_valid = 1'b1; rx_data = 8'h55; tx_ready = 1'b0;
    tick();
    rx_valid = 1'b0;
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", level); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_ready got %b want 1", rx_ready); end
    checks++; if (act !== 1'b0) begin errors++; $display("[TB] FAIL reset_act got %b want 0", act); end
    checks++; if (rx_count !== 32'd0 || tx_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", rx_count, tx_count); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_echo();
    logic [7:0] b [3];
    b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43;
    mode = 2'd0; tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = b[i];
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== b[i]) begin errors++; $display("[TB] FAIL echo_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, b[i]); end
    end
    rx_valid = 1'b0;
    tick();
    checks++; if (tx_valid !== 1'b0 || level !== '0) begin errors++; $display("[TB] FAIL echo_drained got v=%b lvl=%0d want v=0 lvl=0", tx_valid, level); end
  endtask

  task automatic test_modes();
    logic [7:0] din [6];
    logic [1:0] dm [6];
    logic [7:0] ex [6];
    din = '{8'h61, 8'h61, 8'h61, 8'h61, 8'hFF, 8'h5B};
    dm  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    ex  = '{8'h61, 8'h9E, 8'h62, 8'h41, 8'h00, 8'h5B};
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = din[i]; mode = dm[i];
      tick();
    end
    rx_valid = 1'b0; mode = 2'd3; tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== ex[i]) begin errors++; $display("[TB] FAIL mode_out%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, ex[i]); end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mode_drained got v=%b want 0", tx_valid); end
    tx_ready = 1'b0; mode = 2'd0;
  endtask

  task automatic test_backpressure();
    logic [7:0] sent [DEPTH+1];
    int popIdx;
    tx_ready = 1'b0; mode = 2'd0;
    for (int i = 0; i <= DEPTH; i++) sent[i] = 8'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1'b1; rx_data = sent[i];
      tick();
    end
    rx_data = sent[DEPTH];
    tick(); tick();
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("[TB] FAIL bp_full_level got %0d want %0d", level, DEPTH); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_rx_ready got %b want 0", rx_ready); end
    tx_ready = 1'b1;
    popIdx = 0;
    for (int c = 0; c < 4 * DEPTH && popIdx <= DEPTH; c++) begin
      if (tx_valid === 1'b1) begin
        checks++; if (tx_data !== sent[popIdx]) begin errors++; $display("[TB] FAIL bp_order%0d got %h want %h", popIdx, tx_data, sent[popIdx]); end
        popIdx++;
      end
      if (rx_valid && mQ.size() < DEPTH) begin
        tick();
        rx_valid = 1'b0;
      end else begin
        tick();
      end
    end
    checks++; if (popIdx != DEPTH + 1) begin errors++; $display("[TB] FAIL bp_drain_count got %0d want %0d", popIdx, DEPTH + 1); end
    rx_valid = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] b [4];
    tx_ready = 1'b0; mode = 2'd0;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = b[i];
      tick();
    end
    tx_ready = 1'b1; rx_data = b[3];
    tick();
    rx_valid = 1'b0;
    checks++; if (level !== LW'(3)) begin errors++; $display("[TB] FAIL simul_level got %0d want 3", level); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== b[i]) begin errors++; $display("[TB] FAIL simul_order%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, b[i]); end
      tick();
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_flush();
    tx_ready = 1'b0; mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom);
      tick();
    end
    checks++; if (level !== LW'(5)) begin errors++; $display("[TB] FAIL flush_pre_level got %0d want 5", level); end
    flush = 1'b1; rx_data = 8'hAA;
    tick();
    flush = 1'b0; rx_valid = 1'b0;
    checks++; if (level !== '0 || tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got lvl=%0d v=%b want lvl=0 v=0", level, tx_valid); end
    rx_valid = 1'b1; rx_data = 8'h37;
    tick();
    rx_valid = 1'b0;
    checks++; if (level !== LW'(1) || tx_data !== 8'h37) begin errors++; $display("[TB] FAIL flush_after got lvl=%0d d=%h want lvl=1 d=37", level, tx_data); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic test_activity_stats();
    rstn = 1'b0; tick(); rstn = 1'b1; tick();
    tx_ready = 1'b0; mode = 2'd0;
    rx_valid = 1'b1; rx_data = 8'h10;
    tick();
    rx_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      checks++; if (act !== (c <= ACT_CYCLES)) begin errors++; $display("[TB] FAIL act_cycle%0d got %b want %b", c, act, (c <= ACT_CYCLES)); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom);
      tick();
    end
    rx_valid = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    tx_ready = 1'b0;
    checks++; if (rx_count !== (STATS_ON ? 32'd3 : 32'd0)) begin errors++; $display("[TB] FAIL stats_rx got %0d want %0d", rx_count, STATS_ON ? 3 : 0); end
    checks++; if (tx_count !== (STATS_ON ? 32'd2 : 32'd0)) begin errors++; $display("[TB] FAIL stats_tx got %0d want %0d", tx_count, STATS_ON ? 2 : 0); end
    checks++; if (level !== LW'(1)) begin errors++; $display("[TB] FAIL stats_level got %0d want 1", level); end
    rx_valid = 1'b1; rx_data = 8'h99;
    tick(); tick();
    rstn = 1'b0;
    tick();
    checks++; if (level !== '0 || tx_valid !== 1'b0 || rx_ready !== 1'b1 || act !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state got lvl=%0d v=%b rdy=%b act=%b want 0/0/1/0", level, tx_valid, rx_ready, act); end
    checks++; if (rx_count !== 32'd0 || tx_count !== 32'd0) begin errors++; $display("[TB] FAIL midreset_counts got %0d/%0d want 0/0", rx_count, tx_count); end
    rstn = 1'b1; rx_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rx_valid = ($urandom_range(0, 3) != 0);
      tx_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rx_data  = 8'($urandom);
      mode     = 2'($urandom);
      flush    = ($urandom_range(0, 49) == 0);
      tick();
      checks++; if (level !== LW'(mQ.size())) begin errors++; $display("[TB] FAIL rand_level c=%0d got %0d want %0d", c, level, mQ.size()); end
      checks++; if (tx_valid !== (mQ.size() > 0) || rx_ready !== (mQ.size() < DEPTH)) begin errors++; $display("[TB] FAIL rand_flags c=%0d got v=%b rdy=%b want v=%b rdy=%b", c, tx_valid, rx_ready, (mQ.size() > 0), (mQ.size() < DEPTH)); end
      if (mQ.size() > 0) begin
        checks++; if (tx_data !== mQ[0]) begin errors++; $display("[TB] FAIL rand_data c=%0d got %h want %h", c, tx_data, mQ[0]); end
      end
      checks++; if (act !== (mHold > 0)) begin errors++; $display("[TB] FAIL rand_act c=%0d got %b want %b", c, act, (mHold > 0)); end
      checks++; if (rx_count !== expCount(mRx) || tx_count !== expCount(mTx)) begin errors++; $display("[TB] FAIL rand_counts c=%0d got %0d/%0d want %0d/%0d", c, rx_count, tx_count, expCount(mRx), expCount(mTx)); end
    end
    rx_valid = 1'b0; tx_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; flush = 1'b0;
    rx_data = 8'h00; mode = 2'd0;
    mRx = 0; mTx = 0; mHold = 0;
    tick();
    test_reset();
    test_echo();
    test_modes();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_activity_stats();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
